// File: rtl/adder_4_full_adder_bit.sv
// One-bit full adder cell for the explicit ripple-carry chain in adder_4.
// Purely combinational; the carry is generated when both bits are set or propagated when exactly one is.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic prop_s;

  assign prop_s = a ^ b;
  assign s      = prop_s ^ ci;
  assign co     = (a & b) | (ci & prop_s);

endmodule

// File: rtl/adder_4.sv
// WIDTH-bit ripple-carry adder with carry-in/carry-out and a registered result.
// {cout, s} is a + b + cin captured on each rising edge; synchronous reset clears it.
module adder_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;

  assign carry_s[0] = cin;

  // The chain is kept as discrete cells so synthesis sees the carry path explicitly.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_s[i]),
      .s  (sum_s[i]),
      .co (carry_s[i+1])
    );
  end

  // Output register: captures the combinational sum each cycle, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r    <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
    end else begin
      s_r    <= sum_s;
      cout_r <= carry_s[WIDTH];
    end
  end

  assign s    = s_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_adder_4.sv
// Randomized self-checking bench for adder_4 against an integer-arithmetic reference.
module tb_adder_4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;

  int total;
  int bad;

  adder_4 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Apply one operand set, let one edge pass, compare; then disturb inputs and confirm the outputs hold.
  task automatic step(input string tag, input logic r, input int va, input int vb, input int vc);
    int expected;
    int observed;
    @(negedge clk);
    rst = r;
    a   = 4'(va);
    b   = 4'(vb);
    cin = 1'(vc);
    expected = r ? 0 : (va + vb + vc);
    @(posedge clk);
    #1;
    observed = {27'd0, cout, s};
    check_value(tag, observed, expected);
    a   = 4'($urandom_range(15, 0));
    b   = 4'($urandom_range(15, 0));
    cin = 1'($urandom_range(1, 0));
    rst = 1'($urandom_range(1, 0));
    #1;
    observed = {27'd0, cout, s};
    check_value({tag, "_hold"}, observed, expected);
  endtask

  initial begin
    int ra;
    int rb;
    int rc;
    int rr;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a   = 4'd9;
    b   = 4'd9;
    cin = 1'b1;

    step("reset0", 1'b1, 9, 9, 1);
    step("reset1", 1'b1, 9, 9, 1);

    step("zero_path",   1'b0, 0,  0,  1);
    step("no_carry",    1'b0, 0,  13, 0);
    step("carry_out",   1'b0, 15, 10, 1);
    step("full_ripple", 1'b0, 15, 0,  1);
    step("max_sum",     1'b0, 15, 15, 1);

    for (int i = 1; i <= 511; i += 25) begin
      if (i == 251) begin
        step("sweep_rst", 1'b1, (i >> 5) & 15, (i >> 1) & 15, i & 1);
      end else begin
        step("sweep", 1'b0, (i >> 5) & 15, (i >> 1) & 15, i & 1);
      end
    end

    for (int n = 0; n < 300; n++) begin
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      rc = int'($urandom_range(1, 0));
      rr = int'($urandom_range(15, 0));
      step("random", (rr == 0) ? 1'b1 : 1'b0, ra, rb, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
